id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 op_write  in  1  writeback enable from later stage.
REQ-004 pipe_pc / pipe_pc4  in  32  PC and PC+4 of the instruction in ID.
REQ-005 pipe_data  in  32  instruction word (RV32 encoding).
REQ-006 write_addr / write_data  in  32  writeback register index / value.
REQ-007 load_pc_reg_value1 / load_pc_reg_value2  in  32  register-file read data for addr1 / addr2.
REQ-008 load_pc_reg_addr1 / load_pc_reg_addr2  out  32  register-file read indices.
REQ-009 write_pc_reg_addr / write_pc_reg_value  out  32  register-file write index / value.
REQ-010 control_j  out  1  redirect taken; pc_j  out  32  redirect target.
REQ-011 ctrl_ex  out  9  EX/MEM/WB control; pc4_ex  out  32  registered pipe_pc4.
REQ-012 r_data1 / r_data2  out  32  registered operands; extended  out  32 signed  immediate; rd_ex  out  32  destination index.

Function
REQ-013 load_pc_reg_addr1 = zero-extended pipe_data[19:15], addr2 = zero-extended pipe_data[24:20]; combinational, every opcode.
REQ-014 Decode into 12-bit word {branch, jal, jalr, RegWrite, Link, MemToReg, MemRead, MemWrite, ALUop[2:0], ALUSrc}; ctrl_ex = bits [8:0].
REQ-015 Words: ADD 000_100_00_0000, SUB 000_100_00_0010, SLL 000_100_00_1000, SLT 000_100_00_1010, AND 000_100_00_0100, OR 000_100_00_0110 (opcode 0110011, funct3 000/000(f7[5]=1)/001/010/111/110); ADDI 000_100_00_0001 (0010011); LD 000_101_10_0001 (0000011); SD 000_000_01_0001 (0100011); BEQ-class 100_000_00_0000 (1100011); JAL 010_110_00_0000 (1101111); JALR 001_110_00_0000 (1100111).
REQ-016 Unknown opcode or unsupported funct -> all-zero word (bubble), rd_ex 0, control_j 0.
REQ-017 Immediate, sign-extended to 32: I = [31:20]; S = {[31:25],[11:7]}; SB = {[31],[7],[30:25],[11:8],0}; UJ = {[31],[19:12],[20],[30:21],0}; R-type/bubble = 0.
REQ-018 rd_ex = zero-extended pipe_data[11:7] for R/I/JAL/JALR; 0 for S, SB, bubble.
REQ-019 On rising clk: ctrl_ex, pc4_ex, r_data1 <= load_pc_reg_value1, r_data2 <= load_pc_reg_value2, extended, rd_ex, control_j, pc_j update; latency exactly one cycle.
REQ-020 JAL: control_j 1, pc_j = pipe_pc + imm. JALR: control_j 1, pc_j = (load_pc_reg_value1 + imm) with bit0 cleared.
REQ-021 Branch (funct3 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed) compares load_pc_reg_value1/2; taken -> control_j 1, pc_j = pipe_pc + imm; not taken or unsupported funct3 -> control_j 0.
REQ-022 control_j 0 -> pc_j 0.
REQ-023 Write port combinational: op_write=1 and write_addr!=0 -> write_pc_reg_addr = write_addr, write_pc_reg_value = write_data; otherwise both 0 (x0 never modified).
REQ-024 All 32-bit sums wrap modulo 2^32.

Reset
REQ-025 reset_n low: all registered outputs (control_j, pc_j, ctrl_ex, pc4_ex, r_data1, r_data2, extended, rd_ex) go to 0 immediately, including mid-operation; first capture on first rising clk after release.
REQ-026 Combinational outputs (addr1/2, write port) follow inputs during reset.

Configuration
REQ-027 Macro ID_BRANCH_RESOLVE_EN defined: branches resolved in ID per REQ-021.
REQ-028 Macro undefined: opcode 1100011 treated as bubble (ctrl_ex 0, control_j 0, rd_ex 0); all else unchanged.

Verification
REQ-029 ADDI x12,x20,7 (pipe_data {12'd7,5'd20,3'b000,5'd12,7'b0010011}), pipe_pc 400, value1 8 -> addr1 20 immediately; after clk ctrl_ex 100000001, pc4_ex 404, r_data1 8, extended 7, rd_ex 12, control_j 0, pc_j 0.
REQ-030 LD x5,-4(x3) -> ctrl_ex 101100001, extended 0xFFFFFFFC, rd_ex 5.
REQ-031 JAL x1,+8 at pipe_pc 400 -> control_j 1, pc_j 408, ctrl_ex 110000000, rd_ex 1; JALR x1,3(x2), value1 100 -> pc_j 102.
REQ-032 BEQ x1,x2,+16 at pc 200: values 5/5 -> control_j 1, pc_j 216; 5/6 -> control_j 0, pc_j 0 (macro defined); macro undefined -> ctrl_ex 0, control_j 0.
REQ-033 op_write 1, write_addr 12, write_data 15 -> write port 12/15; op_write 0 or write_addr 0 -> 0/0.
REQ-034 Assert reset_n low between clock edges after an ADDI capture -> all registered outputs 0 at once.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: RV32 instruction-decode stage.
// Decodes the instruction in ID into a 12-bit control word and immediate,
// forms register-file read indices and the writeback write port, and
// resolves jumps in ID. Decode results are registered for EX.
// Optional feature macro: ID_BRANCH_RESOLVE_EN. When defined, conditional
// branches (opcode 1100011) are resolved here. When undefined, that opcode
// decodes as a bubble.
module id_stage (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_write,
  input  logic [31:0]        pipe_pc,
  input  logic [31:0]        pipe_pc4,
  input  logic [31:0]        pipe_data,
  input  logic [31:0]        write_addr,
  input  logic [31:0]        write_data,
  input  logic [31:0]        load_pc_reg_value1,
  input  logic [31:0]        load_pc_reg_value2,
  output logic [31:0]        load_pc_reg_addr1,
  output logic [31:0]        load_pc_reg_addr2,
  output logic [31:0]        write_pc_reg_addr,
  output logic [31:0]        write_pc_reg_value,
  output logic               control_j,
  output logic [31:0]        pc_j,
  output logic [8:0]         ctrl_ex,
  output logic [31:0]        pc4_ex,
  output logic [31:0]        r_data1,
  output logic [31:0]        r_data2,
  output logic signed [31:0] extended,
  output logic [31:0]        rd_ex
);

  // Control words: {branch, jal, jalr, RegWrite, Link, MemToReg,
  //                 MemRead, MemWrite, ALUop[2:0], ALUSrc}
  localparam logic [11:0] W_ADD  = 12'b000_100_00_0000;
  localparam logic [11:0] W_SUB  = 12'b000_100_00_0010;
  localparam logic [11:0] W_SLL  = 12'b000_100_00_1000;
  localparam logic [11:0] W_SLT  = 12'b000_100_00_1010;
  localparam logic [11:0] W_AND  = 12'b000_100_00_0100;
  localparam logic [11:0] W_OR   = 12'b000_100_00_0110;
  localparam logic [11:0] W_ADDI = 12'b000_100_00_0001;
  localparam logic [11:0] W_LD   = 12'b000_101_10_0001;
  localparam logic [11:0] W_SD   = 12'b000_000_01_0001;
  localparam logic [11:0] W_JAL  = 12'b010_110_00_0000;
  localparam logic [11:0] W_JALR = 12'b001_110_00_0000;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7b5;
  logic [31:0] w_rd_field;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_uj;
  logic [31:0] w_jalr_sum;

  logic [11:0] w_word;
  logic [31:0] w_imm;
  logic [31:0] w_rd;
  logic        w_take;
  logic [31:0] w_target;

  logic        r_control_j;
  logic [31:0] r_pc_j;
  logic [8:0]  r_ctrl_ex;
  logic [31:0] r_pc4_ex;
  logic [31:0] r_data1_q;
  logic [31:0] r_data2_q;
  logic [31:0] r_extended;
  logic [31:0] r_rd_ex;

  assign w_opcode   = pipe_data[6:0];
  assign w_funct3   = pipe_data[14:12];
  assign w_funct7b5 = pipe_data[30];
  assign w_rd_field = {27'd0, pipe_data[11:7]};
  assign w_imm_i    = {{20{pipe_data[31]}}, pipe_data[31:20]};
  assign w_imm_s    = {{20{pipe_data[31]}}, pipe_data[31:25], pipe_data[11:7]};
  assign w_imm_uj   = {{11{pipe_data[31]}}, pipe_data[31], pipe_data[19:12],
                       pipe_data[20], pipe_data[30:21], 1'b0};
  assign w_jalr_sum = load_pc_reg_value1 + w_imm_i;

`ifdef ID_BRANCH_RESOLVE_EN
  logic [31:0] w_imm_sb;
  logic        w_eq;
  logic        w_lt;
  assign w_imm_sb = {{19{pipe_data[31]}}, pipe_data[31], pipe_data[7],
                     pipe_data[30:25], pipe_data[11:8], 1'b0};
  assign w_eq     = (load_pc_reg_value1 == load_pc_reg_value2);
  assign w_lt     = ($signed(load_pc_reg_value1) < $signed(load_pc_reg_value2));
`endif

  // Register-file read indices come straight from the rs1/rs2 fields.
  assign load_pc_reg_addr1 = {27'd0, pipe_data[19:15]};
  assign load_pc_reg_addr2 = {27'd0, pipe_data[24:20]};

  // Writeback port is suppressed for x0 so it can never be modified.
  assign write_pc_reg_addr  = (op_write && (write_addr != 32'd0)) ? write_addr : 32'd0;
  assign write_pc_reg_value = (op_write && (write_addr != 32'd0)) ? write_data : 32'd0;

  // Decode opcode/funct into control word, immediate, rd and redirect.
  always_comb begin
    w_word   = '0;
    w_imm    = '0;
    w_rd     = '0;
    w_take   = 1'b0;
    w_target = '0;
    case (w_opcode)
      7'b0110011: begin
        case (w_funct3)
          3'b000:  w_word = w_funct7b5 ? W_SUB : W_ADD;
          3'b001:  w_word = W_SLL;
          3'b010:  w_word = W_SLT;
          3'b111:  w_word = W_AND;
          3'b110:  w_word = W_OR;
          default: w_word = '0;
        endcase
        // Unsupported funct leaves a bubble, which carries no rd.
        if (w_word != 12'd0) w_rd = w_rd_field;
      end
      7'b0010011: begin
        w_word = W_ADDI;
        w_imm  = w_imm_i;
        w_rd   = w_rd_field;
      end
      7'b0000011: begin
        w_word = W_LD;
        w_imm  = w_imm_i;
        w_rd   = w_rd_field;
      end
      7'b0100011: begin
        w_word = W_SD;
        w_imm  = w_imm_s;
      end
`ifdef ID_BRANCH_RESOLVE_EN
      7'b1100011: begin
        case (w_funct3)
          3'b000: begin w_word = 12'b100_000_00_0000; w_take = w_eq;  end
          3'b001: begin w_word = 12'b100_000_00_0000; w_take = !w_eq; end
          3'b100: begin w_word = 12'b100_000_00_0000; w_take = w_lt;  end
          3'b101: begin w_word = 12'b100_000_00_0000; w_take = !w_lt; end
          default: w_word = '0;
        endcase
        if (w_word != 12'd0) w_imm = w_imm_sb;
        if (w_take) w_target = pipe_pc + w_imm_sb;
      end
`endif
      7'b1101111: begin
        w_word   = W_JAL;
        w_imm    = w_imm_uj;
        w_rd     = w_rd_field;
        w_take   = 1'b1;
        w_target = pipe_pc + w_imm_uj;
      end
      7'b1100111: begin
        w_word   = W_JALR;
        w_imm    = w_imm_i;
        w_rd     = w_rd_field;
        w_take   = 1'b1;
        w_target = {w_jalr_sum[31:1], 1'b0};
      end
      default: ;
    endcase
  end

  // Pipeline register into EX; cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_control_j <= 1'b0;
      r_pc_j      <= '0;
      r_ctrl_ex   <= '0;
      r_pc4_ex    <= '0;
      r_data1_q   <= '0;
      r_data2_q   <= '0;
      r_extended  <= '0;
      r_rd_ex     <= '0;
    end else begin
      r_control_j <= w_take;
      r_pc_j      <= w_take ? w_target : 32'd0;
      r_ctrl_ex   <= w_word[8:0];
      r_pc4_ex    <= pipe_pc4;
      r_data1_q   <= load_pc_reg_value1;
      r_data2_q   <= load_pc_reg_value2;
      r_extended  <= w_imm;
      r_rd_ex     <= w_rd;
    end
  end

  assign control_j = r_control_j;
  assign pc_j      = r_pc_j;
  assign ctrl_ex   = r_ctrl_ex;
  assign pc4_ex    = r_pc4_ex;
  assign r_data1   = r_data1_q;
  assign r_data2   = r_data2_q;
  assign extended  = r_extended;
  assign rd_ex     = r_rd_ex;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a
// mnemonic-level reference model (instructions are built from a kind plus
// integer fields, and expectations are derived from those same fields).
module tb_id_stage;

`ifdef ID_BRANCH_RESOLVE_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  typedef enum int {
    K_ADD, K_SUB, K_SLL, K_SLT, K_AND, K_OR, K_ADDI, K_LD, K_SD,
    K_BEQ, K_BNE, K_BLT, K_BGE, K_JAL, K_JALR, K_BADOP, K_BADR
  } kind_t;

  logic               clk;
  logic               reset_n;
  logic               op_write;
  logic [31:0]        pipe_pc, pipe_pc4, pipe_data;
  logic [31:0]        write_addr, write_data;
  logic [31:0]        load_pc_reg_value1, load_pc_reg_value2;
  logic [31:0]        load_pc_reg_addr1, load_pc_reg_addr2;
  logic [31:0]        write_pc_reg_addr, write_pc_reg_value;
  logic               control_j;
  logic [31:0]        pc_j;
  logic [8:0]         ctrl_ex;
  logic [31:0]        pc4_ex, r_data1, r_data2;
  logic signed [31:0] extended;
  logic [31:0]        rd_ex;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  id_stage dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .op_write           (op_write),
    .pipe_pc            (pipe_pc),
    .pipe_pc4           (pipe_pc4),
    .pipe_data          (pipe_data),
    .write_addr         (write_addr),
    .write_data         (write_data),
    .load_pc_reg_value1 (load_pc_reg_value1),
    .load_pc_reg_value2 (load_pc_reg_value2),
    .load_pc_reg_addr1  (load_pc_reg_addr1),
    .load_pc_reg_addr2  (load_pc_reg_addr2),
    .write_pc_reg_addr  (write_pc_reg_addr),
    .write_pc_reg_value (write_pc_reg_value),
    .control_j          (control_j),
    .pc_j               (pc_j),
    .ctrl_ex            (ctrl_ex),
    .pc4_ex             (pc4_ex),
    .r_data1            (r_data1),
    .r_data2            (r_data2),
    .extended           (extended),
    .rd_ex              (rd_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs_zero(input string where);
    check({where, ".control_j"}, {31'd0, control_j}, 32'd0);
    check({where, ".pc_j"},      pc_j,               32'd0);
    check({where, ".ctrl_ex"},   {23'd0, ctrl_ex},   32'd0);
    check({where, ".pc4_ex"},    pc4_ex,             32'd0);
    check({where, ".r_data1"},   r_data1,            32'd0);
    check({where, ".r_data2"},   r_data2,            32'd0);
    check({where, ".extended"},  extended,           32'd0);
    check({where, ".rd_ex"},     rd_ex,              32'd0);
  endtask

  // Drive one instruction, check the combinational outputs, clock it in and
  // check the registered outputs against the reference model.
  task automatic run_instr(input kind_t k, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic signed [31:0] imm,
                           input logic [31:0] pc, input logic [31:0] v1, input logic [31:0] v2,
                           input logic wen, input logic [31:0] waddr, input logic [31:0] wdata);
    logic [31:0] instr;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [11:0] e_word;
    logic [31:0] e_ext, e_rd, e_pcj, e_wa, e_wd;
    logic        e_j;
    logic        is_br, br_cond;

    // Encode the instruction from its fields.
    f7 = 7'b0000000;
    f3 = 3'b000;
    case (k)
      K_SUB:  f7 = 7'b0100000;
      K_SLL:  f3 = 3'b001;
      K_SLT:  f3 = 3'b010;
      K_AND:  f3 = 3'b111;
      K_OR:   f3 = 3'b110;
      K_BADR: f3 = 3'b011;
      K_BNE:  f3 = 3'b001;
      K_BLT:  f3 = 3'b100;
      K_BGE:  f3 = 3'b101;
      K_LD:   f3 = 3'b011;
      K_SD:   f3 = 3'b011;
      default: ;
    endcase
    case (k)
      K_ADD, K_SUB, K_SLL, K_SLT, K_AND, K_OR, K_BADR:
        instr = {f7, rs2, rs1, f3, rd, 7'b0110011};
      K_ADDI: instr = {imm[11:0], rs1, f3, rd, 7'b0010011};
      K_LD:   instr = {imm[11:0], rs1, f3, rd, 7'b0000011};
      K_JALR: instr = {imm[11:0], rs1, f3, rd, 7'b1100111};
      K_SD:   instr = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      K_BEQ, K_BNE, K_BLT, K_BGE:
        instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      K_JAL:  instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      default: instr = {imm[24:0], 7'b0110111};
    endcase

    // Reference model: behaviour by instruction kind.
    e_word = 12'd0;
    e_ext  = 32'd0;
    e_rd   = 32'd0;
    e_j    = 1'b0;
    e_pcj  = 32'd0;
    is_br  = (k == K_BEQ) || (k == K_BNE) || (k == K_BLT) || (k == K_BGE);
    br_cond = (k == K_BEQ) ? (v1 == v2) :
              (k == K_BNE) ? (v1 != v2) :
              (k == K_BLT) ? ($signed(v1) < $signed(v2)) :
                             ($signed(v1) >= $signed(v2));
    case (k)
      K_ADD:  begin e_word = 12'b000_100_00_0000; e_rd = 32'(rd); end
      K_SUB:  begin e_word = 12'b000_100_00_0010; e_rd = 32'(rd); end
      K_SLL:  begin e_word = 12'b000_100_00_1000; e_rd = 32'(rd); end
      K_SLT:  begin e_word = 12'b000_100_00_1010; e_rd = 32'(rd); end
      K_AND:  begin e_word = 12'b000_100_00_0100; e_rd = 32'(rd); end
      K_OR:   begin e_word = 12'b000_100_00_0110; e_rd = 32'(rd); end
      K_ADDI: begin e_word = 12'b000_100_00_0001; e_rd = 32'(rd); e_ext = imm; end
      K_LD:   begin e_word = 12'b000_101_10_0001; e_rd = 32'(rd); e_ext = imm; end
      K_SD:   begin e_word = 12'b000_000_01_0001; e_ext = imm; end
      K_JAL:  begin e_word = 12'b010_110_00_0000; e_rd = 32'(rd); e_ext = imm;
                    e_j = 1'b1; e_pcj = pc + imm; end
      K_JALR: begin e_word = 12'b001_110_00_0000; e_rd = 32'(rd); e_ext = imm;
                    e_j = 1'b1; e_pcj = (v1 + imm) & 32'hFFFF_FFFE; end
      default: ;
    endcase
    if (is_br && BR_EN) begin
      e_word = 12'b100_000_00_0000;
      e_ext  = imm;
      e_j    = br_cond;
      e_pcj  = br_cond ? pc + imm : 32'd0;
    end
    e_wa = (wen && waddr != 0) ? waddr : 32'd0;
    e_wd = (wen && waddr != 0) ? wdata : 32'd0;

    @(negedge clk);
    pipe_data          = instr;
    pipe_pc            = pc;
    pipe_pc4           = pc + 32'd4;
    load_pc_reg_value1 = v1;
    load_pc_reg_value2 = v2;
    op_write           = wen;
    write_addr         = waddr;
    write_data         = wdata;
    #1;
    check("addr1", load_pc_reg_addr1, 32'(instr[19:15]));
    check("addr2", load_pc_reg_addr2, 32'(instr[24:20]));
    check("waddr", write_pc_reg_addr, e_wa);
    check("wdata", write_pc_reg_value, e_wd);
    @(posedge clk);
    #1;
    check("ctrl_ex",   {23'd0, ctrl_ex},   {23'd0, e_word[8:0]});
    check("pc4_ex",    pc4_ex,             pc + 32'd4);
    check("r_data1",   r_data1,            v1);
    check("r_data2",   r_data2,            v2);
    check("extended",  extended,           e_ext);
    check("rd_ex",     rd_ex,              e_rd);
    check("control_j", {31'd0, control_j}, {31'd0, e_j});
    check("pc_j",      pc_j,               e_pcj);
    n_txn++;
    $display("txn %0d %s pc=%h data=%h v1=%h v2=%h ctrl_ex=%b ext=%h rd=%0d j=%b pc_j=%h",
             n_txn, k.name(), pc, instr, v1, v2, ctrl_ex, extended, rd_ex, control_j, pc_j);
  endtask

  initial begin
    kind_t             k;
    logic signed [31:0] imm;
    logic [31:0]       v1, v2;

    reset_n = 1'b0; op_write = 1'b0; pipe_pc = '0; pipe_pc4 = '0; pipe_data = '0;
    write_addr = '0; write_data = '0; load_pc_reg_value1 = '0; load_pc_reg_value2 = '0;
    #3;
    check_regs_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Directed: ADDI x12,x20,7 at pc 400 with value1 8.
    run_instr(K_ADDI, 5'd12, 5'd20, 5'd0, 32'sd7, 32'd400, 32'd8, 32'd0, 1'b1, 32'd12, 32'd15);
    // Mid-operation reset clears registered outputs without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check_regs_zero("midreset");
    pipe_data = 32'h00F4_8000;
    #1;
    check("rst.addr1", load_pc_reg_addr1, 32'd9);
    check("rst.addr2", load_pc_reg_addr2, 32'd15);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed: LD x5,-4(x3); JAL x1,+8; JALR x1,3(x2); BEQ taken / not taken.
    run_instr(K_LD,   5'd5, 5'd3, 5'd0, -32'sd4, 32'd500, 32'd77, 32'd1, 1'b0, 32'd12, 32'd15);
    run_instr(K_JAL,  5'd1, 5'd0, 5'd0, 32'sd8,  32'd400, 32'd0,  32'd0, 1'b1, 32'd0,  32'd15);
    run_instr(K_JALR, 5'd1, 5'd2, 5'd0, 32'sd3,  32'd400, 32'd100, 32'd0, 1'b1, 32'd31, 32'hDEAD_BEEF);
    run_instr(K_BEQ,  5'd0, 5'd1, 5'd2, 32'sd16, 32'd200, 32'd5,  32'd5, 1'b0, 32'd3,  32'd1);
    run_instr(K_BEQ,  5'd0, 5'd1, 5'd2, 32'sd16, 32'd200, 32'd5,  32'd6, 1'b0, 32'd3,  32'd1);
    run_instr(K_BADOP, 5'd0, 5'd0, 5'd0, 32'sh00AB_CDEF, 32'd64, 32'd1, 32'd2, 1'b1, 32'd4, 32'd9);
    // Wrap-around of pc + imm.
    run_instr(K_JAL,  5'd7, 5'd0, 5'd0, -32'sd16, 32'd8, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);

    // Randomized instructions.
    for (int i = 0; i < 300; i++) begin
      k = kind_t'($urandom_range(0, 16));
      case (k)
        K_BEQ, K_BNE, K_BLT, K_BGE: imm = 32'($urandom_range(0, 4095)) * 2 - 32'sd4096;
        K_JAL: imm = 32'($urandom_range(0, 1048575)) * 2 - 32'sd1048576;
        default: imm = 32'($urandom_range(0, 4095)) - 32'sd2048;
      endcase
      if (k == K_BADOP) imm = 32'($urandom);
      v1 = $urandom;
      v2 = ($urandom_range(0, 1) == 0) ? v1 : $urandom;
      run_instr(k, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), imm, $urandom, v1, v2,
                1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
